// File: rtl/sysctrl_cmd_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sysctrl_cmd_master : byte-framed system-control link initiator (cmd + 0-4 payload bytes)
// Revision: 1.0
// ----------------------------------------------------------------------------
module sysctrl_cmd_master #(
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [7:0]  cmd,
  input  logic [2:0]  len,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        data_out_strobe,
  output logic        data_out_start,
  output logic [7:0]  data_out,
  input  logic [7:0]  resp_in
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_GAPW = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [3:0] c_gap_m1 = 4'(GAP - 1);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [2:0]  r_idx;
  logic [2:0]  r_len;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [7:0]  r_data_out;

  logic [1:0]  w_prev_lane;
  logic [1:0]  w_next_lane;

  // r_idx counts payload bytes already sent, so the byte in flight is lane r_idx-1
  assign w_prev_lane = 2'(r_idx - 3'd1);
  assign w_next_lane = r_idx[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= 3'd0;
      r_len      <= 3'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_data_out <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_len      <= (len > 3'd4) ? 3'd4 : len;
            r_wdata    <= wdata;
            r_rdata    <= 32'd0;
            r_data_out <= cmd;
            r_state    <= S_CMD;
          end
        end
        S_CMD: begin
          r_cnt   <= c_gap_m1;
          r_idx   <= 3'd0;
          r_state <= S_GAPW;
        end
        S_GAPW: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            if (r_idx != 3'd0) begin
              r_rdata[{w_prev_lane, 3'b000} +: 8] <= resp_in;
            end
            if (r_idx < r_len) begin
              r_data_out <= r_wdata[{w_next_lane, 3'b000} +: 8];
              r_state    <= S_DATA;
            end else begin
              r_state <= S_FIN;
            end
          end
        end
        S_DATA: begin
          r_idx   <= r_idx + 3'd1;
          r_cnt   <= c_gap_m1;
          r_state <= S_GAPW;
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy            = (r_state == S_CMD) || (r_state == S_GAPW) || (r_state == S_DATA);
  assign done            = (r_state == S_FIN);
  assign data_out_strobe = (r_state == S_CMD) || (r_state == S_DATA);
  assign data_out_start  = (r_state == S_CMD);
  assign data_out        = r_data_out;
  assign rdata           = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sysctrl_cmd_master.sv
`default_nettype none
// Scoreboard bench for sysctrl_cmd_master with a behavioural responder and frame-level reference model.
module tb_sysctrl_cmd_master;

  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [7:0]  cmd = 8'd0;
  logic [2:0]  len = 3'd0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done, data_out_strobe, data_out_start;
  logic [31:0] rdata;
  logic [7:0]  data_out;
  logic [7:0]  resp_in;

  sysctrl_cmd_master #(.GAP(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd), .len(len), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .data_out_strobe(data_out_strobe), .data_out_start(data_out_start),
    .data_out(data_out), .resp_in(resp_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int         at;
    logic       start;
    logic [7:0] data;
  } byte_t;

  byte_t       byte_q[$];
  logic [31:0] frame_q[$];

  // Reference model: one outstanding frame, accepted at m_k, done at m_D
  bit m_active = 1'b0;
  int m_k = 0;
  int m_D = 0;
  int last_strobe = -1;

  function automatic logic [7:0] reply(input logic [7:0] c, input int i, input logic [7:0] b);
    logic [31:0] id_tbl;
    id_tbl = 32'h0002425c;
    if (c == 8'h00) return id_tbl[8*i +: 8];
    return b ^ 8'h3C ^ 8'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Sysctrl-like responder: registers a reply one cycle after each payload strobe
  logic [7:0]  r_rcmd;
  logic [7:0]  r_rsel;
  int          r_ri;
  logic [15:0] system_scanlines = 16'd0;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_in <= 8'd0;
      r_rcmd  <= 8'd0;
      r_rsel  <= 8'd0;
      r_ri    <= 0;
    end else if (data_out_strobe) begin
      if (data_out_start) begin
        r_rcmd  <= data_out;
        r_ri    <= 0;
        resp_in <= 8'hEE;
      end else begin
        resp_in <= reply(r_rcmd, r_ri, data_out);
        r_ri    <= r_ri + 1;
        if (r_ri == 0) r_rsel <= data_out;
        if (r_rcmd == 8'h04 && r_ri == 1 && r_rsel == 8'h53) system_scanlines <= {8'd0, data_out};
      end
    end
  end

  // Monitor: compares every cycle against the model and pops the scoreboard on strobe/done
  always @(negedge clk) begin
    if (!reset) begin
      byte_t e;
      check("busy", {31'd0, busy}, {31'd0, m_active && cyc > m_k && cyc < m_D});
      check("done", {31'd0, done}, {31'd0, m_active && cyc == m_D});
      if (data_out_strobe) begin
        if (byte_q.size() == 0) begin
          fail_now("unexpected_strobe");
        end else begin
          e = byte_q.pop_front();
          check("strobe_cycle", cyc, e.at);
          check("strobe_start", {31'd0, data_out_start}, {31'd0, e.start});
          check("strobe_data", {24'd0, data_out}, {24'd0, e.data});
        end
        if (last_strobe >= 0) check("strobe_spacing_ok", {31'd0, (cyc - last_strobe) >= GAP}, 32'd1);
        last_strobe = cyc;
      end else begin
        check("start_without_strobe", {31'd0, data_out_start}, 32'd0);
      end
      if (done) begin
        if (frame_q.size() == 0) fail_now("unexpected_done");
        else check("rdata_at_done", rdata, frame_q.pop_front());
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] c, input logic [2:0] l, input logic [31:0] w);
    int          k;
    int          nb;
    logic [31:0] exp_r;
    logic [7:0]  b;
    k = cyc;
    req = 1'b1; cmd = c; len = l; wdata = w;
    if (!m_active || k > m_D) begin
      nb = (l > 3'd4) ? 4 : int'(l);
      exp_r = 32'd0;
      byte_q.push_back('{k + 1, 1'b1, c});
      for (int i = 0; i < nb; i++) begin
        b = w[8*i +: 8];
        byte_q.push_back('{k + 1 + (i + 1) * GAP, 1'b0, b});
        exp_r[8*i +: 8] = reply(c, i, b);
      end
      frame_q.push_back(exp_r);
      m_active = 1'b1;
      m_k = k;
      m_D = k + 1 + (nb + 1) * GAP;
    end
    @(posedge clk); #1;
    req = 1'b0; cmd = 8'($urandom); len = 3'($urandom); wdata = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_strobe"}, {31'd0, data_out_strobe}, 32'd0);
    check({tag, "_start"}, {31'd0, data_out_start}, 32'd0);
    check({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
  endtask

  initial begin
    int s;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Identification read: three replies from the responder
    issue(8'h00, 3'd3, 32'h0);
    wait_until(m_D + 1);
    check("id_rdata", rdata, 32'h0002425c);

    // Scanline register write
    issue(8'h04, 3'd2, 32'h0000_0153);
    wait_until(m_D + 1);
    check("scanlines", {16'd0, system_scanlines}, 32'd1);

    // Command-only frame
    issue(8'h01, 3'd0, 32'hFFFF_FFFF);
    wait_until(m_D + 1);
    check("len0_rdata", rdata, 32'd0);

    // Length clamp and ignored req while busy
    issue(8'h07, 3'd7, 32'hDDCC_BBAA);
    repeat (3) @(posedge clk);
    #1;
    issue(8'h09, 3'd1, 32'h1234_5678);
    wait_until(m_D + 2);

    // Reset during the second payload byte's gap
    issue(8'h00, 3'd3, 32'h0);
    s = m_k + 1 + 2 * GAP;
    wait_until(s + 1);
    check("rdata_before_reset", rdata, 32'h0000_005c);
    #1 reset = 1'b1;
    #1 check_all_zero("async_reset");
    byte_q.delete();
    frame_q.delete();
    m_active = 1'b0;
    last_strobe = -1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (GAP * 4) @(posedge clk);
    #1;
    issue(8'h00, 3'd3, 32'h0);
    wait_until(m_D + 1);
    check("id_after_reset", rdata, 32'h0002425c);

    // req in the FIN cycle is ignored; req on the next cycle is accepted
    issue(8'h02, 3'd1, 32'h0000_00A5);
    wait_until(m_D);
    issue(8'h0B, 3'd2, 32'h0000_7711);
    check("back_to_back_accept", m_k, m_D - (1 + 3 * GAP));
    issue(8'h0C, 3'd1, 32'h0000_0001);
    wait_until(m_D + 1);

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      issue(c, 3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        issue(8'($urandom), 3'($urandom_range(0, 7)), $urandom);
      end
      wait_until(m_D + 1 + $urandom_range(0, 3));
    end

    wait_until(m_D + 4);
    check("byte_q_drained", byte_q.size(), 32'd0);
    check("frame_q_drained", frame_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
